alu_multicycle: RTL

Parametrised, slice-serial successor to the 64-bit combinational ALU. It computes NOR/XOR/ADD/SUB on WIDTH-bit operands by processing one SLICE-bit slice per clock, LSB slice first, with the carry held in a register between slices. The block trades latency for area and sits behind a valid/ready handshake, so it can replace the combinational ALU on any datapath that can tolerate multi-cycle results.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_slice.sv | 35 +++
 rtl/alu_multicycle.sv | 125 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the slice-serial ALU: operation codes and FSM states.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_NOR = 2'b00,
        OP_XOR = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } alu_state_t;

endpackage

// File: rtl/alu_slice.sv
// One SLICE-bit slice of the ALU. Purely combinational; the top feeds it one
// operand slice per cycle and keeps the carry between slices in a register.
module alu_slice
    import alu_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a_s,
    input  logic [SLICE-1:0] b_s,
    input  logic             cin,
    input  logic [1:0]       op,
    output logic [SLICE-1:0] s_s,
    output logic             cout
);

    logic [SLICE:0]   w_sum;
    logic [SLICE-1:0] w_b_eff;

    // Subtraction reuses the adder with an inverted B; the caller supplies the +1 via cin.
    always_comb begin
        w_b_eff = (alu_op_t'(op) == OP_SUB) ? ~b_s : b_s;
        w_sum   = {1'b0, a_s} + {1'b0, w_b_eff} + {{SLICE{1'b0}}, cin};
        s_s     = '0;
        cout    = 1'b0;
        case (alu_op_t'(op))
            OP_NOR:  s_s = ~(a_s | b_s);
            OP_XOR:  s_s = a_s ^ b_s;
            default: begin
                s_s  = w_sum[SLICE-1:0];
                cout = w_sum[SLICE];
            end
        endcase
    end

endmodule

// File: rtl/alu_multicycle.sv
// Slice-serial ALU: accepts one operand bundle, computes it SLICE bits per
// clock (LSB slice first) and presents the result until the consumer takes it.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             zero
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    alu_state_t       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    alu_op_t          r_op;
    logic             r_carry;
    logic             r_cout;
    logic             r_out_valid;
    logic [CW-1:0]    r_cnt;

    logic [SLICE-1:0] w_a_arr [NSLICE];
    logic [SLICE-1:0] w_b_arr [NSLICE];
    logic [NSLICE-1:0] w_slice_en;
    logic [SLICE-1:0] w_a_slice;
    logic [SLICE-1:0] w_b_slice;
    logic [SLICE-1:0] w_s_slice;
    logic             w_cout_slice;
    logic             w_last;

    // Split the captured operands into slices and decode which result slice is written this cycle.
    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slices
        assign w_a_arr[gi]    = r_a[gi*SLICE +: SLICE];
        assign w_b_arr[gi]    = r_b[gi*SLICE +: SLICE];
        assign w_slice_en[gi] = (r_state == RUN) && (r_cnt == CW'(gi));
    end

    assign w_a_slice = w_a_arr[r_cnt];
    assign w_b_slice = w_b_arr[r_cnt];
    assign w_last    = (r_cnt == CW'(NSLICE - 1));

    alu_slice #(.SLICE(SLICE)) u_slice (
        .a_s  (w_a_slice),
        .b_s  (w_b_slice),
        .cin  (r_carry),
        .op   (r_op),
        .s_s  (w_s_slice),
        .cout (w_cout_slice)
    );

    // Control FSM with operand capture, carry chaining across slices and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_s         <= '0;
            r_op        <= OP_NOR;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_op    <= alu_op_t'(op);
                        r_cnt   <= '0;
                        // Only arithmetic ops consume the incoming carry.
                        r_carry <= op[1] ? cin : 1'b0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NSLICE; i++) begin
                        if (w_slice_en[i]) begin
                            r_s[i*SLICE +: SLICE] <= w_s_slice;
                        end
                    end
                    r_carry <= w_cout_slice;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_cout      <= w_cout_slice;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = r_out_valid;
    assign s         = r_s;
    assign cout      = r_cout;
    assign zero      = (r_s == '0);

endmodule
